// File: rtl/uart_led_cmd.sv
// ASCII command responder: parses "Lhh<CR>" / "?<CR>" from the UART receive stream,
// drives the LED register and streams back a short ack, error or readback string.
module uart_led_cmd #(
   parameter int unsigned LED_WIDTH      = 6,
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [LED_WIDTH-1:0] led_value,
   output logic                 cmd_error
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   typedef enum logic [2:0] {
      IDLE, HEX_HI, HEX_LO, WAIT_CR, Q_CR, DISCARD, RESP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           byte_q, byte_d;
   logic [3:0][7:0]      rbuf_q, rbuf_d;
   logic [1:0]           idx_q, idx_d;
   logic [1:0]           last_q, last_d;
   logic                 tready_q, tready_d;
   logic                 tvalid_q, tvalid_d;
   logic [7:0]           tdata_q, tdata_d;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic                 err_q, err_d;

   logic       s_acc;
   logic       m_hs;
   logic       wait_st;
   logic [7:0] led_ext;

   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_nib(input logic [7:0] c);
      if (c <= 8'h39)      return 4'(c - 8'h30);
      else if (c <= 8'h46) return 4'(c - 8'h37);
      else                 return 4'(c - 8'h57);
   endfunction

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
   endfunction

   // Next-state, response buffer and output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      rbuf_d   = rbuf_q;
      idx_d    = idx_q;
      last_d   = last_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      led_d    = led_q;
      err_d    = 1'b0;

      s_acc   = s_axis_tvalid && tready_q;
      m_hs    = tvalid_q && m_axis_tready;
      led_ext = 8'(led_q);
      wait_st = (state_q == HEX_HI) || (state_q == HEX_LO) || (state_q == WAIT_CR) ||
                (state_q == Q_CR) || (state_q == DISCARD);

      // An accepted byte always beats an expiring timeout
      if (wait_st) begin
         if (s_acc) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end

      case (state_q)
         IDLE: if (s_acc) begin
            if (s_axis_tdata == 8'h4C)                                  state_d = HEX_HI;
            else if (s_axis_tdata == 8'h3F)                             state_d = Q_CR;
            else if (s_axis_tdata == CH_CR || s_axis_tdata == CH_LF)    state_d = IDLE;
            else                                                        state_d = DISCARD;
         end
         HEX_HI: if (s_acc) begin
            if (is_hex(s_axis_tdata)) begin
               byte_d[7:4] = hex_nib(s_axis_tdata);
               state_d     = HEX_LO;
            end else begin
               state_d = DISCARD;
            end
         end
         HEX_LO: if (s_acc) begin
            if (is_hex(s_axis_tdata)) begin
               byte_d[3:0] = hex_nib(s_axis_tdata);
               state_d     = WAIT_CR;
            end else begin
               state_d = DISCARD;
            end
         end
         WAIT_CR: if (s_acc) begin
            if (s_axis_tdata == CH_CR) begin
               led_d     = LED_WIDTH'(byte_q);
               rbuf_d[0] = 8'h4B;
               rbuf_d[1] = CH_CR;
               rbuf_d[2] = CH_LF;
               last_d    = 2'd2;
               state_d   = RESP;
            end else begin
               state_d = DISCARD;
            end
         end
         Q_CR: if (s_acc) begin
            if (s_axis_tdata == CH_CR) begin
               rbuf_d[0] = hex_chr(led_ext[7:4]);
               rbuf_d[1] = hex_chr(led_ext[3:0]);
               rbuf_d[2] = CH_CR;
               rbuf_d[3] = CH_LF;
               last_d    = 2'd3;
               state_d   = RESP;
            end else begin
               state_d = DISCARD;
            end
         end
         DISCARD: if (s_acc && s_axis_tdata == CH_CR) begin
            rbuf_d[0] = 8'h45;
            rbuf_d[1] = CH_CR;
            rbuf_d[2] = CH_LF;
            last_d    = 2'd2;
            err_d     = 1'b1;
            state_d   = RESP;
         end
         RESP: if (m_hs) begin
            if (idx_q == last_q) begin
               tvalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               idx_d   = idx_q + 2'd1;
               tdata_d = rbuf_q[idx_q + 2'd1];
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != RESP && state_d == RESP) begin
         tvalid_d = 1'b1;
         tdata_d  = rbuf_d[0];
         idx_d    = 2'd0;
      end

      tready_d = (state_d != RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         byte_q   <= '0;
         rbuf_q   <= '0;
         idx_q    <= '0;
         last_q   <= '0;
         tready_q <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         led_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         rbuf_q   <= rbuf_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         tready_q <= tready_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         led_q    <= led_d;
         err_q    <= err_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign led_value     = led_q;
   assign cmd_error     = err_q;

endmodule
